pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//   Parametrised elastic pipeline register between any two CPU stages (IF/ID .. MEM/WB).
//   Carries a data payload and a control payload with a valid/ready handshake.
//   Optional 2-entry skid buffer breaks the ready path; synchronous flush squashes in-flight beats.
//   The control payload is forced to 0 on bubbles, so downstream regwrite/memtoreg/jump never fire spuriously.
// PARAMETERS
//   DATA_W  165  data payload width (default: pc_next4 32 + mem_data 64 + ex_res 64 + rd 5)
//   CTRL_W  3    control payload width; zeroed on bubble, flush and reset
//   SKID    1    1: 2-entry skid buffer, registered in_ready_o; 0: single entry, combinational in_ready_o
// PORTS
//   clk_i        in   1       clock, rising edge
//   rst_ni       in   1       reset, synchronous, active-low
//   flush_i      in   1       squash all held beats this cycle
//   in_valid_i   in   1       upstream beat valid
//   in_ready_o   out  1       stage can accept a beat
//   in_data_i    in   DATA_W  upstream data payload
//   in_ctrl_i    in   CTRL_W  upstream control payload
//   out_valid_o  out  1       downstream beat valid
//   out_ready_i  in   1       downstream accepts the beat
//   out_data_o   out  DATA_W  head data payload
//   out_ctrl_o   out  CTRL_W  head control payload; 0 whenever out_valid_o=0
//   occ_o        out  2       entries held (0..2; max 1 when SKID=0)
// BEHAVIOUR
//   - Clock/reset: one clock, clk_i; reset rst_ni is synchronous, active-low.
//   - Reset (rst_ni=0 at posedge): state EMPTY; out_valid_o=0, out_data_o=0, out_ctrl_o=0, occ_o=0.
//     in_ready_o=1 from the first cycle after reset. Inputs sampled while rst_ni=0 are ignored.
//   - Transfers: acc = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
//   - Latency: an accepted beat appears on out_* the next cycle when the stage was EMPTY,
//     or was FULL with pop.
//   - FSM for SKID=1 (main reg M, skid reg S; in_ready_o = (state!=SKID), from a register):
//       EMPTY: acc -> FULL, M<=in.
//       FULL : acc&pop -> FULL, M<=in; !acc&pop -> EMPTY;
//              acc&!pop -> SKID, S<=in; else hold.
//       SKID : pop -> FULL, M<=S; else hold. No accept is possible in SKID.
//   - SKID=0: states EMPTY/FULL only. in_ready_o = (state==EMPTY) | out_ready_i, combinational.
//     Transitions are the same as above, without SKID.
//   - out_valid_o = (state!=EMPTY). out_data_o = M; it holds its last value when EMPTY.
//     out_ctrl_o = valid ? M.ctrl : 0.
//   - Ordering: beats leave in acceptance order; no beat is duplicated or lost except by flush.
//   - Flush (flush_i=1 at posedge): next state EMPTY, occ_o=0, out_ctrl_o=0.
//     A beat offered the same cycle is dropped, even if acc=1.
//     A pop in the same cycle still counts as delivered downstream.
//     Flush has priority over every transition.
//   - Reset overrides flush.
//   - Stall: out_ready_i=0 holds out_* stable (no glitch, no change) until pop.
//   - occ_o: EMPTY=0, FULL=1, SKID=2.
// TESTING
//   1) Reset, then in_valid_i=1, data=0xA5, ctrl=3'b101, out_ready_i=1
//      -> next cycle out_valid_o=1, out_data_o=0xA5, out_ctrl_o=101, occ_o=1.
//   2) SKID=1: stream 1,2,3 with out_ready_i=0 from beat 2
//      -> occ_o=2 and in_ready_o=0 after beat 2; beat 3 is held off.
//      Release out_ready_i -> outputs 1,2,3 in order, no duplicates.
//   3) State SKID (occ_o=2), pulse flush_i with in_valid_i=1
//      -> next cycle occ_o=0, out_valid_o=0, out_ctrl_o=0; the offered beat never appears.
//   4) SKID=0: full, out_ready_i=1, in_valid_i=1 continuously
//      -> one beat per cycle, in_ready_o=1 every cycle, occ_o stays 1.
//   5) Assert rst_ni=0 for 1 cycle while occ_o=2
//      -> all outputs 0, occ_o=0, in_ready_o=1 next cycle; the prior beats are never emitted.
//   6) Random valid/ready/flush for 10k cycles against a scoreboard
//      -> order preserved, zero loss outside flush, out_ctrl_o=0 whenever out_valid_o=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register between two CPU stages: data + control payload, valid/ready
// handshake, optional 2-entry skid buffer and synchronous flush.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 165,
    parameter int unsigned CTRL_W = 3,
    parameter int unsigned SKID   = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [1:0]        occ_o
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
    logic              valid_q, valid_d;
    logic              rdy_q, rdy_d;
    logic              acc;
    logic              pop;

    // Skid variant takes ready from a flop; single-entry variant passes downstream ready through.
    assign in_ready_o = (SKID != 0) ? rdy_q : ((state_q == ST_EMPTY) | out_ready_i);

    assign acc = in_valid_i & in_ready_o;
    assign pop = valid_q & out_ready_i;

    // Next-state and payload steering; m_ctrl is cleared on every entry into EMPTY
    // so out_ctrl_o is zero on bubbles straight from the register.
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        m_ctrl_d = m_ctrl_q;
        s_data_d = s_data_q;
        s_ctrl_d = s_ctrl_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    state_d  = ST_FULL;
                    m_data_d = in_data_i;
                    m_ctrl_d = in_ctrl_i;
                end
            end
            ST_FULL: begin
                if (acc && pop) begin
                    m_data_d = in_data_i;
                    m_ctrl_d = in_ctrl_i;
                end else if (pop) begin
                    state_d  = ST_EMPTY;
                    m_ctrl_d = '0;
                end else if (acc && (SKID != 0)) begin
                    state_d  = ST_SKID;
                    s_data_d = in_data_i;
                    s_ctrl_d = in_ctrl_i;
                end
            end
            ST_SKID: begin
                if (pop) begin
                    state_d  = ST_FULL;
                    m_data_d = s_data_q;
                    m_ctrl_d = s_ctrl_q;
                end
            end
            default: begin
                state_d  = ST_EMPTY;
                m_ctrl_d = '0;
            end
        endcase

        if (flush_i) begin
            state_d  = ST_EMPTY;
            m_ctrl_d = '0;
        end
    end

    assign valid_d = (state_d != ST_EMPTY);
    assign rdy_d   = (state_d != ST_SKID);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_EMPTY;
            m_data_q <= '0;
            m_ctrl_q <= '0;
            s_data_q <= '0;
            s_ctrl_q <= '0;
            valid_q  <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            m_data_q <= m_data_d;
            m_ctrl_q <= m_ctrl_d;
            s_data_q <= s_data_d;
            s_ctrl_q <= s_ctrl_d;
            valid_q  <= valid_d;
            rdy_q    <= rdy_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = m_data_q;
    assign out_ctrl_o  = m_ctrl_q;
    assign occ_o       = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomized checks of pipe_stage_reg; a SKID=1 and a SKID=0 instance share stimulus.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 165;
    localparam int unsigned CW = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;

    logic          rdy1, val1, rdy0, val0;
    logic [DW-1:0] data1, data0;
    logic [CW-1:0] ctrl1, ctrl0;
    logic [1:0]    occ1, occ0;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(rdy1), .in_data_i(in_data), .in_ctrl_i(in_ctrl),
        .out_valid_o(val1), .out_ready_i(out_ready), .out_data_o(data1), .out_ctrl_o(ctrl1),
        .occ_o(occ1)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(rdy0), .in_data_i(in_data), .in_ctrl_i(in_ctrl),
        .out_valid_o(val0), .out_ready_i(out_ready), .out_data_o(data0), .out_ctrl_o(ctrl0),
        .occ_o(occ0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({val1, rdy1, occ1, ctrl1} !== {1'b0, 1'b1, 2'd0, 3'd0} || data1 !== '0) begin
            errors++;
            $display("FAIL reset_skid1 got v%b r%b occ%0d ctrl%0h data%0h exp v0 r1 occ0 ctrl0 data0",
                     val1, rdy1, occ1, ctrl1, data1);
        end
        checks++;
        if ({val0, occ0, ctrl0} !== {1'b0, 2'd0, 3'd0} || data0 !== '0 || rdy0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_skid0 got v%b r%b occ%0d ctrl%0h data%0h exp v0 r1 occ0 ctrl0 data0",
                     val0, rdy0, occ0, ctrl0, data0);
        end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_data = DW'(32'hA5); in_ctrl = 3'b101;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({val1, occ1, ctrl1} !== {1'b1, 2'd1, 3'b101} || data1 !== DW'(32'hA5)) begin
            errors++;
            $display("FAIL single_beat got v%b occ%0d ctrl%b data%0h exp v1 occ1 ctrl101 dataa5",
                     val1, occ1, ctrl1, data1);
        end
        tick();
        checks++;
        if ({val1, occ1, ctrl1} !== {1'b0, 2'd0, 3'd0} || data1 !== DW'(32'hA5)) begin
            errors++;
            $display("FAIL single_drain got v%b occ%0d ctrl%b data%0h exp v0 occ0 ctrl000 dataa5 held",
                     val1, occ1, ctrl1, data1);
        end
    endtask

    task automatic test_skid_stream();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_data = DW'(1); in_ctrl = 3'd1;
        tick();
        checks++;
        if ({val1, rdy1, occ1, ctrl1} !== {1'b1, 1'b1, 2'd1, 3'd1} || data1 !== DW'(1)) begin
            errors++;
            $display("FAIL stream_b1 got v%b r%b occ%0d ctrl%0h data%0h exp v1 r1 occ1 ctrl1 data1",
                     val1, rdy1, occ1, ctrl1, data1);
        end
        out_ready = 1'b0; in_data = DW'(2); in_ctrl = 3'd2;
        tick();
        checks++;
        if ({val1, rdy1, occ1, ctrl1} !== {1'b1, 1'b0, 2'd2, 3'd1} || data1 !== DW'(1)) begin
            errors++;
            $display("FAIL stream_skid got v%b r%b occ%0d ctrl%0h data%0h exp v1 r0 occ2 ctrl1 data1",
                     val1, rdy1, occ1, ctrl1, data1);
        end
        in_data = DW'(3); in_ctrl = 3'd3;
        tick();
        checks++;
        if ({val1, rdy1, occ1, ctrl1} !== {1'b1, 1'b0, 2'd2, 3'd1} || data1 !== DW'(1)) begin
            errors++;
            $display("FAIL stream_hold got v%b r%b occ%0d ctrl%0h data%0h exp v1 r0 occ2 ctrl1 data1",
                     val1, rdy1, occ1, ctrl1, data1);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({val1, rdy1, occ1, ctrl1} !== {1'b1, 1'b1, 2'd1, 3'd2} || data1 !== DW'(2)) begin
            errors++;
            $display("FAIL stream_b2 got v%b r%b occ%0d ctrl%0h data%0h exp v1 r1 occ1 ctrl2 data2",
                     val1, rdy1, occ1, ctrl1, data1);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({val1, rdy1, occ1, ctrl1} !== {1'b1, 1'b1, 2'd1, 3'd3} || data1 !== DW'(3)) begin
            errors++;
            $display("FAIL stream_b3 got v%b r%b occ%0d ctrl%0h data%0h exp v1 r1 occ1 ctrl3 data3",
                     val1, rdy1, occ1, ctrl1, data1);
        end
        tick();
        checks++;
        if ({val1, rdy1, occ1, ctrl1} !== {1'b0, 1'b1, 2'd0, 3'd0} || data1 !== DW'(3)) begin
            errors++;
            $display("FAIL stream_end got v%b r%b occ%0d ctrl%0h data%0h exp v0 r1 occ0 ctrl0 data3",
                     val1, rdy1, occ1, ctrl1, data1);
        end
    endtask

    task automatic test_flush_skid();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_data = DW'(32'h11); in_ctrl = 3'd7;
        tick();
        out_ready = 1'b0; in_data = DW'(32'h22); in_ctrl = 3'd6;
        tick();
        checks++;
        if (occ1 !== 2'd2) begin
            errors++;
            $display("FAIL flush_setup got occ%0d exp occ2", occ1);
        end
        flush = 1'b1; in_data = DW'(32'h33); in_ctrl = 3'd5;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if ({val1, rdy1, occ1, ctrl1} !== {1'b0, 1'b1, 2'd0, 3'd0}) begin
            errors++;
            $display("FAIL flush_skid got v%b r%b occ%0d ctrl%0h exp v0 r1 occ0 ctrl0",
                     val1, rdy1, occ1, ctrl1);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({val1, occ1, ctrl1} !== {1'b0, 2'd0, 3'd0}) begin
                errors++;
                $display("FAIL flush_noleak got v%b occ%0d ctrl%0h data%0h exp v0 occ0 ctrl0",
                         val1, occ1, ctrl1, data1);
            end
        end
    endtask

    task automatic test_skid0_stream();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = DW'(32'h100 + i);
            in_ctrl = CW'(i);
            #1;
            checks++;
            if (rdy0 !== 1'b1) begin
                errors++;
                $display("FAIL s0_ready beat%0d got %b exp 1", i, rdy0);
            end
            tick();
            checks++;
            if ({val0, occ0, ctrl0} !== {1'b1, 2'd1, CW'(i)} || data0 !== DW'(32'h100 + i)) begin
                errors++;
                $display("FAIL s0_beat%0d got v%b occ%0d ctrl%0h data%0h exp v1 occ1 ctrl%0h data%0h",
                         i, val0, occ0, ctrl0, data0, i, 32'h100 + i);
            end
        end
        out_ready = 1'b0; in_data = DW'(32'h1FF); in_ctrl = 3'd7;
        #1;
        checks++;
        if (rdy0 !== 1'b0) begin
            errors++;
            $display("FAIL s0_stall_ready got %b exp 0", rdy0);
        end
        tick();
        checks++;
        if ({val0, occ0, ctrl0} !== {1'b1, 2'd1, 3'd5} || data0 !== DW'(32'h105)) begin
            errors++;
            $display("FAIL s0_stall_hold got v%b occ%0d ctrl%0h data%0h exp v1 occ1 ctrl5 data105",
                     val0, occ0, ctrl0, data0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++;
        if ({val0, occ0, ctrl0} !== {1'b0, 2'd0, 3'd0}) begin
            errors++;
            $display("FAIL s0_drain got v%b occ%0d ctrl%0h exp v0 occ0 ctrl0", val0, occ0, ctrl0);
        end
    endtask

    task automatic test_reset_in_skid();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_data = DW'(32'h44); in_ctrl = 3'd4;
        tick();
        out_ready = 1'b0; in_data = DW'(32'h55); in_ctrl = 3'd3;
        tick();
        rst_n = 1'b0; out_ready = 1'b1; in_data = DW'(32'h77); in_ctrl = 3'd7;
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        checks++;
        if ({val1, rdy1, occ1, ctrl1} !== {1'b0, 1'b1, 2'd0, 3'd0} || data1 !== '0) begin
            errors++;
            $display("FAIL rst_skid got v%b r%b occ%0d ctrl%0h data%0h exp v0 r1 occ0 ctrl0 data0",
                     val1, rdy1, occ1, ctrl1, data1);
        end
        tick();
        checks++;
        if ({val1, occ1, ctrl1} !== {1'b0, 2'd0, 3'd0}) begin
            errors++;
            $display("FAIL rst_noleak got v%b occ%0d ctrl%0h data%0h exp v0 occ0 ctrl0",
                     val1, occ1, ctrl1, data1);
        end
    endtask

    task automatic test_random();
        beat_t q1[$];
        beat_t q0[$];
        beat_t b;
        logic  er1, er0;
        int    seq = 0;
        do_reset();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            seq++;
            in_data   = DW'(seq);
            in_ctrl   = CW'($urandom_range(0, 7));
            b.data    = in_data;
            b.ctrl    = in_ctrl;
            #1;
            er1 = (q1.size() != 2);
            er0 = (q0.size() == 0) || out_ready;
            checks++;
            if (rdy1 !== er1 || val1 !== (q1.size() != 0) || occ1 !== 2'(q1.size()) ||
                (q1.size() != 0 && (data1 !== q1[0].data || ctrl1 !== q1[0].ctrl)) ||
                (q1.size() == 0 && ctrl1 !== '0)) begin
                errors++;
                $display("FAIL rand_skid1 cyc%0d got v%b r%b occ%0d ctrl%0h data%0h exp v%b r%b occ%0d head%0h",
                         cyc, val1, rdy1, occ1, ctrl1, data1, q1.size() != 0, er1, q1.size(),
                         (q1.size() != 0) ? q1[0].data : '0);
            end
            checks++;
            if (rdy0 !== er0 || val0 !== (q0.size() != 0) || occ0 !== 2'(q0.size()) ||
                (q0.size() != 0 && (data0 !== q0[0].data || ctrl0 !== q0[0].ctrl)) ||
                (q0.size() == 0 && ctrl0 !== '0)) begin
                errors++;
                $display("FAIL rand_skid0 cyc%0d got v%b r%b occ%0d ctrl%0h data%0h exp v%b r%b occ%0d head%0h",
                         cyc, val0, rdy0, occ0, ctrl0, data0, q0.size() != 0, er0, q0.size(),
                         (q0.size() != 0) ? q0[0].data : '0);
            end
            if (q1.size() != 0 && out_ready) void'(q1.pop_front());
            if (flush) q1.delete();
            else if (in_valid && er1) q1.push_back(b);
            if (q0.size() != 0 && out_ready) void'(q0.pop_front());
            if (flush) q0.delete();
            else if (in_valid && er0) q0.push_back(b);
            tick();
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_skid_stream();
        test_flush_skid();
        test_skid0_stream();
        test_reset_in_skid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
